encrypt_32: RTL and testbench

ENCRYPT_32 -- requirements
Module: encrypt_32

---
 rtl/encrypt_32.sv | 101 ++++++++++
 tb/tb_encrypt_32.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_32.sv
// SPECK-32/64 encryption core: one round per clock, round keys read live from the key schedule.
// Valid/ready handshakes on plaintext and ciphertext; losing keys_ready mid-run aborts the block.
module encrypt_32 #(
  parameter int unsigned ROUNDS = 22
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [351:0] round_keys,
  input  logic         keys_ready,
  input  logic [31:0]  pt,
  input  logic         pt_valid,
  output logic         pt_ready,
  output logic [31:0]  ct,
  output logic         ct_valid,
  input  logic         ct_ready,
  output logic         busy
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;

  logic [15:0] k_rnd;
  logic [15:0] x_rnd;
  logic [15:0] y_rnd;

  // Round datapath: x' = (ROR(x,7) + y) ^ k, y' = ROL(y,2) ^ x'.
  assign k_rnd = round_keys[{cnt_q, 4'b0000} +: 16];
  assign x_rnd = ({x_q[6:0], x_q[15:7]} + y_q) ^ k_rnd;
  assign y_rnd = {y_q[13:0], y_q[15:14]} ^ x_rnd;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (pt_valid && keys_ready) begin
          x_d     = pt[31:16];
          y_d     = pt[15:0];
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!keys_ready) begin
          // Keys went away under us: drop the partial result.
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          x_d   = x_rnd;
          y_d   = y_rnd;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LastRound) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (ct_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    pt_ready = (state_q == StIdle) && keys_ready;
    busy     = (state_q == StRun);
    ct_valid = (state_q == StDone);
    ct       = ct_valid ? {x_q, y_q} : 32'h0;
  end

endmodule

// File: tb/tb_encrypt_32.sv
// Bench for encrypt_32: whole-block SPECK model plus handshake model, directed scenarios and
// randomized traffic, all outputs compared every cycle.
module tb_encrypt_32;

  logic         clock;
  logic         reset;
  logic [351:0] round_keys;
  logic         keys_ready;
  logic [31:0]  pt;
  logic         pt_valid;
  logic         pt_ready;
  logic [31:0]  ct;
  logic         ct_valid;
  logic         ct_ready;
  logic         busy;

  encrypt_32 #(.ROUNDS(22)) dut (
    .clock      (clock),
    .reset      (reset),
    .round_keys (round_keys),
    .keys_ready (keys_ready),
    .pt         (pt),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .ct         (ct),
    .ct_valid   (ct_valid),
    .ct_ready   (ct_ready),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Full 22-round encryption in one go.
  function automatic logic [31:0] speck_model(input logic [31:0] p, input logic [351:0] rk);
    logic [15:0] x, y;
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < 22; i++) begin
      x = (ror16(x, 7) + y) ^ rk[16*i +: 16];
      y = rol16(y, 2) ^ x;
    end
    return {x, y};
  endfunction

  // SPECK-32/64 key schedule; key words are {l2, l1, l0, k0}.
  function automatic logic [351:0] expand_key(input logic [63:0] key);
    logic [15:0]  k;
    logic [15:0]  l [0:23];
    logic [351:0] rk;
    k    = key[15:0];
    l[0] = key[31:16];
    l[1] = key[47:32];
    l[2] = key[63:48];
    rk   = '0;
    for (int i = 0; i < 22; i++) begin
      rk[16*i +: 16] = k;
      if (i < 21) begin
        l[i+3] = (k + ror16(l[i], 7)) ^ 16'(i);
        k      = rol16(k, 2) ^ l[i+3];
      end
    end
    return rk;
  endfunction

  function automatic logic [351:0] rand_keys();
    logic [351:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model of the handshake: phase, rounds remaining, precomputed result.
  typedef enum int {MIdle, MRun, MDone} mphase_e;
  mphase_e       m_phase = MIdle;
  int            m_left  = 0;
  logic [31:0]   m_res   = '0;
  bit            m_fresh = 1'b1;
  int unsigned   cyc     = 0;
  int unsigned   acc_q[$];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset) begin
      m_phase <= MIdle;
      m_fresh <= 1'b1;
    end else begin
      case (m_phase)
        MIdle: if (pt_valid && keys_ready) begin
          m_phase <= MRun;
          m_left  <= 22;
          m_res   <= speck_model(pt, round_keys);
          m_fresh <= 1'b0;
          acc_q.push_back(cyc + 1);
        end
        MRun: begin
          if (!keys_ready) m_phase <= MIdle;
          else begin
            m_left <= m_left - 1;
            if (m_left == 1) m_phase <= MDone;
          end
        end
        MDone: if (ct_ready) m_phase <= MIdle;
        default: m_phase <= MIdle;
      endcase
    end
  end

  always @(negedge clock) begin
    check("pt_ready", 32'(pt_ready), 32'((m_phase == MIdle) && keys_ready));
    check("busy", 32'(busy), 32'(m_phase == MRun));
    check("ct_valid", 32'(ct_valid), 32'(m_phase == MDone));
    if (m_phase == MDone) check("ct", ct, m_res);
    else if (m_fresh) check("ct_after_reset", ct, 32'h0);
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic accept_one(input logic [31:0] p);
    pt       = p;
    pt_valid = 1'b1;
    step();
    pt_valid = 1'b0;
  endtask

  task automatic wait_ct_valid(input int budget, output int busy_cycles, output bit ok);
    busy_cycles = 0;
    ok          = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (ct_valid) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL ct_valid_timeout got=0 exp=1");
    end
  endtask

  logic [351:0] rk_vec;
  int           nb;
  bit           ok;
  bit           seen;
  int           base;
  int           r;

  initial begin
    reset      = 1'b0;
    round_keys = '0;
    keys_ready = 1'b0;
    pt         = '0;
    pt_valid   = 1'b0;
    ct_ready   = 1'b0;
    repeat (3) step();
    check("reset_ct", ct, 32'h0);
    reset = 1'b1;

    // Pin the model against the published test vector.
    rk_vec = expand_key(64'h1918111009080100);
    check("ks_k0", 32'(rk_vec[15:0]), 32'h0100);
    check("ks_k1", 32'(rk_vec[31:16]), 32'h1512);
    check("model_vector", speck_model(32'h6574694c, rk_vec), 32'ha86842f2);

    // A: nominal run, latency and busy width.
    round_keys = rk_vec;
    keys_ready = 1'b1;
    step();
    accept_one(32'h6574694c);
    wait_ct_valid(40, nb, ok);
    if (ok) begin
      check("A_latency", cyc - acc_q[$], 32'd22);
      check("A_busy_cycles", 32'(nb), 32'd22);
      check("A_ct", ct, 32'ha86842f2);
    end
    ct_ready = 1'b1;
    step();
    ct_ready = 1'b0;
    check("A_pt_ready_after", 32'(pt_ready), 32'd1);

    // B: downstream stalls for 10 cycles.
    accept_one(32'h6574694c);
    wait_ct_valid(40, nb, ok);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("B_ct_hold", ct, 32'ha86842f2);
      check("B_pt_ready_low", 32'(pt_ready), 32'd0);
    end
    ct_ready = 1'b1;
    step();
    ct_ready = 1'b0;
    check("B_ct_valid_drop", 32'(ct_valid), 32'd0);
    check("B_pt_ready_after", 32'(pt_ready), 32'd1);

    // C: keys_ready drops at RUN cycle 10.
    accept_one(32'h6574694c);
    repeat (9) step();
    keys_ready = 1'b0;
    step();
    check("C_abort_busy", 32'(busy), 32'd0);
    check("C_abort_ct_valid", 32'(ct_valid), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      seen |= ct_valid;
    end
    check("C_no_ct_valid", 32'(seen), 32'd0);
    step();
    keys_ready = 1'b1;
    accept_one(32'h6574694c);
    wait_ct_valid(40, nb, ok);
    check("C_ct_after_retry", ct, 32'ha86842f2);
    ct_ready = 1'b1;
    step();
    ct_ready = 1'b0;

    // D: reset mid-RUN, then reset while holding a result.
    accept_one(32'h6574694c);
    repeat (4) step();
    reset = 1'b0;
    step();
    check("D_run_busy", 32'(busy), 32'd0);
    check("D_run_ct_valid", 32'(ct_valid), 32'd0);
    check("D_run_ct", ct, 32'h0);
    check("D_run_pt_ready", 32'(pt_ready), 32'd1);
    reset = 1'b1;
    accept_one(32'h6574694c);
    wait_ct_valid(40, nb, ok);
    reset = 1'b0;
    step();
    check("D_done_ct_valid", 32'(ct_valid), 32'd0);
    check("D_done_ct", ct, 32'h0);
    reset = 1'b1;

    // E: pt_valid held high with ct_ready high; 23 cycles separate consecutive accepts.
    step();
    base     = acc_q.size();
    pt_valid = 1'b1;
    ct_ready = 1'b1;
    for (int i = 0; i < 150 && acc_q.size() < base + 4; i++) begin
      pt = $urandom;
      step();
    end
    if (acc_q.size() < base + 4) begin
      n_total++;
      $display("FAIL E_accepts got=%0d exp=4", acc_q.size() - base);
    end else begin
      for (int j = 1; j < 4; j++) begin
        check("E_spacing", acc_q[base+j] - acc_q[base+j-1] - 1, 32'd23);
      end
    end
    pt_valid = 1'b0;
    repeat (30) step();
    ct_ready = 1'b0;

    // F: no accept without keys, then an all-zero key and plaintext.
    keys_ready = 1'b0;
    pt_valid   = 1'b1;
    pt         = '0;
    repeat (5) begin
      step();
      check("F_pt_ready_low", 32'(pt_ready), 32'd0);
      check("F_busy_low", 32'(busy), 32'd0);
    end
    round_keys = '0;
    keys_ready = 1'b1;
    accept_one(32'h0);
    wait_ct_valid(40, nb, ok);
    check("F_zero_ct", ct, speck_model(32'h0, '0));
    ct_ready = 1'b1;
    step();
    ct_ready = 1'b0;

    // Randomized traffic; keys only change while keys_ready is low.
    for (int i = 0; i < 3000; i++) begin
      step();
      r = int'($urandom_range(0, 99));
      if (!keys_ready) begin
        if (r < 30) begin
          round_keys = rand_keys();
          keys_ready = 1'b1;
        end
      end else if (r < 2) begin
        keys_ready = 1'b0;
      end
      pt_valid = ($urandom_range(0, 3) != 0);
      pt       = $urandom;
      ct_ready = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 299) != 0);
    end
    reset    = 1'b1;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    repeat (30) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
